// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full-adder cell used by the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per cycle, LSB first, through a single full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 64) begin : gen_width_check
    $error("serial_adder: WIDTH must be in the range 2..64");
  end

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              fa_s, fa_co;
  logic [WIDTH-1:0]  acc_shift;

  fa_bit u_fa_bit (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          // Subtraction is a + ~b + 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        acc_d   = acc_shift;
        if (cnt_q == LastCnt) begin
          // carry_q is the carry into the MSB during the last bit.
          sum_d   = acc_shift;
          cout_d  = fa_co;
          ovf_d   = fa_co ^ carry_q;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected results, monitor checks on done.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_total = 0;
  int           n_pass  = 0;
  int           ncyc    = 0;
  int           busy_len = 0;
  logic [W+1:0] held = '0;
  exp_t         mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Reference: plain arithmetic on whole operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t       r;
    logic [W:0] full;
    if (s) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      r.ovf  = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
    end else begin
      full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    end
    r.due = 0;
    return r;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      check("reset_outputs", {busy, done, sum, cout, ovf}, '0);
      held     = '0;
      busy_len = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("sum", sum, mon_e.sum);
          check("cout", cout, mon_e.cout);
          check("ovf", ovf, mon_e.ovf);
          check("done_latency", ncyc, mon_e.due);
        end
        held = {sum, cout, ovf};
      end else begin
        check("result_hold", {sum, cout, ovf}, held);
      end
      if (busy) busy_len++;
      else if (busy_len != 0) begin
        check("busy_cycles", busy_len, W + 1);
        busy_len = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (busy && k < 200);
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub);
    exp_t e;
    wait_idle();
    a     = ia;
    b     = ib;
    cin   = icin;
    sub   = isub;
    start = 1'b1;
    e     = model(ia, ib, icin, isub);
    e.due = ncyc + W + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs so any late sampling corrupts the result.
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    check("reset_async", {busy, done, sum, cout, ovf}, '0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors; the first two run back-to-back.
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h7F, 8'h00, 1'b1, 1'b0);
    issue(8'h10, 8'h20, 1'b1, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 1'b1);

    // start pulses and operand changes during RUN must be ignored.
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    sub   = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset mid-RUN aborts with no done pulse.
    issue(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(8'h03, 8'h04, 1'b0, 1'b0);

    // Randomized operations with random idle gaps.
    repeat (40) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
